// File: rtl/key_scan_ctrl_pkg.sv
// key_scan_pkg: shared types and helpers for the key scan controller.
//   key_evt_t  : one queued key event {code, press}
//   KEY_CODE_W : width of the key index carried in an event
//   sat_step   : one saturating integrator step (up on 1, down on 0)
package key_scan_pkg;

   localparam int KEY_CODE_W = 4;

   typedef struct packed {
      logic [KEY_CODE_W-1:0] code;
      logic                  press;
   } key_evt_t;

   // Integrator update: count up toward cnt_max while the key reads 1,
   // down toward 0 while it reads 0, never wrapping.
   function automatic int unsigned sat_step(input int unsigned cnt,
                                            input logic        up,
                                            input int unsigned cnt_max);
      if (up) return (cnt >= cnt_max) ? cnt_max : cnt + 32'd1;
      else    return (cnt == 32'd0)   ? 32'd0   : cnt - 32'd1;
   endfunction

endpackage

// File: rtl/key_scan_ctrl_if.sv
// key_scan_ctrl_if: key event handshake between the scan controller and
// the consuming CPU side.
//   evt_valid : event available at the head of the queue
//   evt_ready : consumer accepts the head event
//   evt_code  : key index of the head event
//   evt_press : 1 = press, 0 = release
// master = event producer (key_scan_ctrl), slave = event consumer.
interface key_scan_ctrl_if;
   import key_scan_pkg::*;

   logic                  evt_valid;
   logic                  evt_ready;
   logic [KEY_CODE_W-1:0] evt_code;
   logic                  evt_press;

   modport master (output evt_valid, output evt_code, output evt_press,
                   input  evt_ready);
   modport slave  (input  evt_valid, input  evt_code, input  evt_press,
                   output evt_ready);
endinterface

// File: rtl/key_scan_ctrl_evt_fifo.sv
// key_evt_fifo: small event queue with sticky overflow flag.
//   clk, rst    : clock, asynchronous active-low reset
//   i_push/i_din: enqueue an event
//   i_pop       : consumer accepts head (ignored while empty)
//   o_dout      : head entry, read straight from storage (0 when empty)
//   o_valid     : queue non-empty
//   i_ovf_clr   : clears o_ovf (a same-cycle overflow wins)
//   o_ovf       : sticky, set when a push hits a full queue with no pop
// DEPTH must be a power of two, at least 2.
module key_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic         o_valid,
   input  logic         i_ovf_clr,
   output logic         o_ovf
);
   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinct.
   logic [AW:0]  r_wr;
   logic [AW:0]  r_rd;
   logic         r_ovf;
   logic [W-1:0] r_mem [DEPTH];

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_wr_en;
   logic w_drop;

   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = i_pop & ~w_empty;
   // A pop in the same cycle frees the slot the push lands in.
   assign w_wr_en = i_push & (~w_full | w_pop);
   assign w_drop  = i_push & w_full & ~w_pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_wr_en) r_wr <= r_wr + (AW+1)'(1);
         if (w_pop)   r_rd <= r_rd + (AW+1)'(1);
         if (w_drop)         r_ovf <= 1'b1;
         else if (i_ovf_clr) r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_din;
   end

   assign o_dout  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
   assign o_valid = ~w_empty;
   assign o_ovf   = r_ovf;

endmodule

// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: time-multiplexed debouncer for NKEYS push-buttons.
// One shared integrator update per scan tick, keys serviced round-robin;
// debounced level changes are queued as events for the CPU.
//   clk, rst  : clock, asynchronous active-low reset
//   keys_in   : raw asynchronous key levels (1 = pressed)
//   key_state : debounced level per key
//   evt       : event handshake (key_scan_ctrl_if.master)
//   ovf       : sticky event-queue overflow flag
//   ovf_clr   : clears ovf
// Build option KEY_SCAN_RELEASE_EN: when defined, release events are
// queued too; otherwise only presses are queued, evt_press is tied to 1
// and queue entries hold just the key code.
module key_scan_ctrl
   import key_scan_pkg::*;
#(
   parameter int NKEYS      = 8,
   parameter int CNT_W      = 6,
   parameter int HI_TH      = 48,
   parameter int LO_TH      = 16,
   parameter int SCAN_DIV   = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NKEYS-1:0]      keys_in,
   output logic [NKEYS-1:0]      key_state,
   key_scan_ctrl_if.master       evt,
   output logic                  ovf,
   input  logic                  ovf_clr
);
   localparam int          PRE_W   = $clog2(SCAN_DIV);
   localparam int          PTR_W   = $clog2(NKEYS);
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [CNT_W-1:0] HI_C = CNT_W'(HI_TH);
   localparam logic [CNT_W-1:0] LO_C = CNT_W'(LO_TH);

   logic [NKEYS-1:0] r_sync1;
   logic [NKEYS-1:0] r_sync2;
   logic [NKEYS-1:0] r_state;
   logic [PRE_W-1:0] r_pre;
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_cnt [NKEYS];

   logic             w_tick;
   logic             w_sample;
   logic             w_cur_st;
   logic             w_rise;
   logic             w_fall;
   logic             w_push;
   logic [CNT_W-1:0] w_cnt_new;

   assign w_tick    = (r_pre == PRE_W'(SCAN_DIV-1));
   assign w_sample  = r_sync2[r_ptr];
   assign w_cur_st  = r_state[r_ptr];
   assign w_cnt_new = CNT_W'(sat_step(32'(r_cnt[r_ptr]), w_sample, CNT_MAX));
   // Hysteresis: decisions use the post-update count of the serviced key.
   assign w_rise    = ~w_cur_st & (w_cnt_new >= HI_C);
   assign w_fall    =  w_cur_st & (w_cnt_new <  LO_C);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_state <= '0;
         r_pre   <= '0;
         r_ptr   <= '0;
         for (int k = 0; k < NKEYS; k++) r_cnt[k] <= '0;
      end else begin
         r_sync1 <= keys_in;
         r_sync2 <= r_sync1;
         if (w_tick) begin
            r_pre        <= '0;
            r_ptr        <= (r_ptr == PTR_W'(NKEYS-1)) ? '0 : r_ptr + PTR_W'(1);
            r_cnt[r_ptr] <= w_cnt_new;
            if (w_rise)      r_state[r_ptr] <= 1'b1;
            else if (w_fall) r_state[r_ptr] <= 1'b0;
         end else begin
            r_pre <= r_pre + PRE_W'(1);
         end
      end
   end

   assign key_state = r_state;

`ifdef KEY_SCAN_RELEASE_EN
   localparam int EVT_W = KEY_CODE_W + 1;
   key_evt_t w_din;
   key_evt_t w_dout;

   assign w_push        = w_tick & (w_rise | w_fall);
   assign w_din         = {KEY_CODE_W'(r_ptr), w_rise};
   assign evt.evt_code  = w_dout.code;
   assign evt.evt_press = w_dout.press;
`else
   localparam int EVT_W = KEY_CODE_W;
   logic [EVT_W-1:0] w_din;
   logic [EVT_W-1:0] w_dout;

   // Releases still clear key_state above but are never queued.
   assign w_push        = w_tick & w_rise;
   assign w_din         = KEY_CODE_W'(r_ptr);
   assign evt.evt_code  = w_dout;
   assign evt.evt_press = 1'b1;
`endif

   // Event is written on the same edge that registers key_state.
   key_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EVT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_din     (w_din),
      .i_pop     (evt.evt_ready),
      .o_dout    (w_dout),
      .o_valid   (evt.evt_valid),
      .i_ovf_clr (ovf_clr),
      .o_ovf     (ovf)
   );

endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb_key_scan_ctrl: scenario bench for key_scan_ctrl with NKEYS=8, SCAN_DIV=4.
// Expected events are queued when keys are driven and compared as they leave
// the DUT. Edge n (n=1 is the first posedge after reset release) is a scan
// tick when n % SCAN_DIV == 0; tick j = n/SCAN_DIV services key (j-1) % NKEYS.
module tb_key_scan_ctrl;
   import key_scan_pkg::*;

   localparam int NK    = 8;
   localparam int SD    = 4;
   localparam int ROUND = NK * SD;
   // Edge of the 48th visit to key k when held from reset release.
   localparam int PRESS_EDGE0 = (1 + 47 * NK) * SD;

`ifdef KEY_SCAN_RELEASE_EN
   localparam bit REL_EN = 1'b1;
`else
   localparam bit REL_EN = 1'b0;
`endif
   localparam logic PRESS_IDLE = REL_EN ? 1'b0 : 1'b1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          ovf;
   logic [NK-1:0] keys_in = '0;
   logic [NK-1:0] key_state;

   key_scan_ctrl_if u_if ();

   key_evt_t sb[$];
   int       n_pass  = 0;
   int       n_total = 0;

   always #5 clk = ~clk;

   key_scan_ctrl #(
      .NKEYS    (NK),
      .SCAN_DIV (SD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .keys_in   (keys_in),
      .key_state (key_state),
      .evt       (u_if),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   task automatic do_reset(input logic [NK-1:0] k);
      u_if.evt_ready = 1'b0;
      ovf_clr        = 1'b0;
      rst            = 1'b0;
      keys_in        = k;
      sb.delete();
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic step_to(inout int n, input int target);
      while (n < target) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic wait_valid(input int limit, inout int n, output bit ok);
      ok = 1'b0;
      while (n < limit && !ok) begin
         @(posedge clk); #1;
         n++;
         ok = u_if.evt_valid;
      end
   endtask

   task automatic pop_head(inout int n);
      u_if.evt_ready = 1'b1;
      @(posedge clk); #1;
      n++;
      u_if.evt_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; keys_in = '0; u_if.evt_ready = 1'b0;
      repeat (2) @(posedge clk); #1;
      n_total++;
      if (u_if.evt_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", u_if.evt_valid);
      else n_pass++;
      n_total++;
      if (u_if.evt_code !== 4'd0) $display("FAIL rst_code: got %0d want 0", u_if.evt_code);
      else n_pass++;
      n_total++;
      if (u_if.evt_press !== PRESS_IDLE) $display("FAIL rst_press: got %b want %b", u_if.evt_press, PRESS_IDLE);
      else n_pass++;
      n_total++;
      if (ovf !== 1'b0 || key_state !== '0) $display("FAIL rst_state: got ovf=%b ks=%h want 0/00", ovf, key_state);
      else n_pass++;
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 10 * ROUND; i++) begin
         @(posedge clk); #1;
         n_total++;
         if (key_state !== '0 || u_if.evt_valid !== 1'b0 || ovf !== 1'b0)
            $display("FAIL idle_cycle%0d: got ks=%h v=%b ovf=%b want 00/0/0", i, key_state, u_if.evt_valid, ovf);
         else n_pass++;
      end
   endtask

   task automatic test_press_release;
      int       n;
      bit       ok;
      key_evt_t exp;
      do_reset(8'h08);
      n = 0;
      sb.push_back('{code: 4'd3, press: 1'b1});
      wait_valid(PRESS_EDGE0 + 3 * SD + ROUND, n, ok);
      n_total++;
      if (!ok || n != PRESS_EDGE0 + 3 * SD) $display("FAIL press_latency: got edge %0d want %0d", n, PRESS_EDGE0 + 3 * SD);
      else n_pass++;
      n_total++;
      if (key_state !== 8'h08) $display("FAIL press_state: got %h want 08", key_state);
      else n_pass++;
      exp = sb.pop_front();
      n_total++;
      if (u_if.evt_code !== exp.code || u_if.evt_press !== exp.press)
         $display("FAIL press_evt: got %0d/%b want %0d/%b", u_if.evt_code, u_if.evt_press, exp.code, exp.press);
      else n_pass++;
      pop_head(n);
      n_total++;
      if (u_if.evt_valid !== 1'b0) $display("FAIL press_popped: got valid %b want 0", u_if.evt_valid);
      else n_pass++;
      // Hold long enough for the integrator to saturate at 63.
      n = 0;
      step_to(n, 20 * ROUND);
      keys_in = '0;
      if (REL_EN) sb.push_back('{code: 4'd3, press: 1'b0});
      n = 0;
      while (n < 50 * ROUND && key_state[3] !== 1'b0) begin
         @(posedge clk); #1;
         n++;
      end
      n_total++;
      if (n < 47 * ROUND || n > 49 * ROUND)
         $display("FAIL release_latency: got %0d cycles want %0d..%0d", n, 47 * ROUND, 49 * ROUND);
      else n_pass++;
      if (REL_EN) begin
         exp = sb.pop_front();
         n_total++;
         if (u_if.evt_valid !== 1'b1 || u_if.evt_code !== exp.code || u_if.evt_press !== exp.press)
            $display("FAIL release_evt: got v=%b %0d/%b want 1 %0d/%b", u_if.evt_valid, u_if.evt_code, u_if.evt_press, exp.code, exp.press);
         else n_pass++;
         pop_head(n);
      end else begin
         n_total++;
         if (u_if.evt_valid !== 1'b0) $display("FAIL release_no_evt: got valid %b want 0", u_if.evt_valid);
         else n_pass++;
      end
   endtask

   task automatic test_bounce;
      int n;
      do_reset(8'h20);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step_to(n, n + ROUND);
         n_total++;
         if (u_if.evt_valid !== 1'b0 || key_state !== '0)
            $display("FAIL bounce%0d: got v=%b ks=%h want 0/00", i, u_if.evt_valid, key_state);
         else n_pass++;
         keys_in[5] = ~keys_in[5];
      end
   endtask

   task automatic test_overflow;
      int       n;
      key_evt_t exp;
      do_reset(8'h3F);
      for (int k = 0; k < 4; k++) sb.push_back('{code: 4'(k), press: 1'b1});
      n = 0;
      step_to(n, PRESS_EDGE0 + 3 * SD);
      n_total++;
      if (u_if.evt_valid !== 1'b1 || ovf !== 1'b0)
         $display("FAIL ovf_full_no_drop: got v=%b ovf=%b want 1/0", u_if.evt_valid, ovf);
      else n_pass++;
      step_to(n, PRESS_EDGE0 + 6 * SD);
      n_total++;
      if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf);
      else n_pass++;
      n_total++;
      if (key_state !== 8'h3F) $display("FAIL ovf_state: got %h want 3f", key_state);
      else n_pass++;
      ovf_clr = 1'b1;
      step_to(n, n + 1);
      ovf_clr = 1'b0;
      n_total++;
      if (ovf !== 1'b0) $display("FAIL ovf_clr: got %b want 0", ovf);
      else n_pass++;
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         n_total++;
         if (u_if.evt_valid !== 1'b1 || u_if.evt_code !== exp.code || u_if.evt_press !== exp.press)
            $display("FAIL ovf_drain: got v=%b %0d/%b want 1 %0d/%b", u_if.evt_valid, u_if.evt_code, u_if.evt_press, exp.code, exp.press);
         else n_pass++;
         pop_head(n);
      end
      n_total++;
      if (u_if.evt_valid !== 1'b0) $display("FAIL ovf_drained: got valid %b want 0", u_if.evt_valid);
      else n_pass++;
   endtask

   task automatic test_full_push_pop;
      int       n;
      key_evt_t exp;
      do_reset(8'h1F);
      for (int k = 0; k < 4; k++) sb.push_back('{code: 4'(k), press: 1'b1});
      n = 0;
      // Queue holds keys 0..3; key 4's event lands on the next edge.
      step_to(n, PRESS_EDGE0 + 4 * SD - 1);
      exp = sb.pop_front();
      n_total++;
      if (u_if.evt_valid !== 1'b1 || u_if.evt_code !== exp.code || ovf !== 1'b0)
         $display("FAIL fpp_head: got v=%b code=%0d ovf=%b want 1 %0d 0", u_if.evt_valid, u_if.evt_code, ovf, exp.code);
      else n_pass++;
      u_if.evt_ready = 1'b1;
      sb.push_back('{code: 4'd4, press: 1'b1});
      step_to(n, n + 1);
      u_if.evt_ready = 1'b0;
      n_total++;
      if (ovf !== 1'b0) $display("FAIL fpp_no_ovf: got %b want 0", ovf);
      else n_pass++;
      step_to(n, n + 3);
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         n_total++;
         if (u_if.evt_valid !== 1'b1 || u_if.evt_code !== exp.code || u_if.evt_press !== exp.press)
            $display("FAIL fpp_drain: got v=%b %0d/%b want 1 %0d/%b", u_if.evt_valid, u_if.evt_code, u_if.evt_press, exp.code, exp.press);
         else n_pass++;
         pop_head(n);
      end
      n_total++;
      if (u_if.evt_valid !== 1'b0) $display("FAIL fpp_occupancy: got valid %b want 0", u_if.evt_valid);
      else n_pass++;
   endtask

   task automatic test_reset_midrun;
      int       n;
      bit       ok;
      key_evt_t exp;
      do_reset(8'h07);
      n = 0;
      step_to(n, PRESS_EDGE0 + SD + 1);
      n_total++;
      if (u_if.evt_valid !== 1'b1 || u_if.evt_code !== 4'd0)
         $display("FAIL mid_queued: got v=%b code=%0d want 1 0", u_if.evt_valid, u_if.evt_code);
      else n_pass++;
      keys_in = 8'h04;
      rst = 1'b0;
      #1;
      n_total++;
      if (u_if.evt_valid !== 1'b0 || key_state !== '0)
         $display("FAIL mid_rst_async: got v=%b ks=%h want 0/00", u_if.evt_valid, key_state);
      else n_pass++;
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      sb.push_back('{code: 4'd2, press: 1'b1});
      n = 0;
      wait_valid(PRESS_EDGE0 + 2 * SD + ROUND, n, ok);
      n_total++;
      if (!ok || n != PRESS_EDGE0 + 2 * SD) $display("FAIL mid_latency: got edge %0d want %0d", n, PRESS_EDGE0 + 2 * SD);
      else n_pass++;
      exp = sb.pop_front();
      n_total++;
      if (u_if.evt_code !== exp.code || u_if.evt_press !== exp.press || key_state !== 8'h04)
         $display("FAIL mid_evt: got %0d/%b ks=%h want %0d/%b ks=04", u_if.evt_code, u_if.evt_press, key_state, exp.code, exp.press);
      else n_pass++;
      pop_head(n);
      step_to(n, n + 4 * ROUND);
      n_total++;
      if (u_if.evt_valid !== 1'b0) $display("FAIL mid_single: got valid %b want 0", u_if.evt_valid);
      else n_pass++;
   endtask

   initial begin
      u_if.evt_ready = 1'b0;
      test_reset();
      test_press_release();
      test_bounce();
      test_overflow();
      test_full_push_pop();
      test_reset_midrun();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
